// File: rtl/rr_arbiter_pkg.sv
// Shared types, constants and the circular-priority helper for rr_arbiter.
// Used by the RTL and by the bench reference model.
package rr_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  // Index of the first set bit of req[n-1:0], scanning circularly from last+1.
  // Returns last when nothing is set; callers qualify with |req.
  function automatic logic [2:0] next_rr(input logic [7:0] req, input logic [2:0] last,
                                         input int unsigned n);
    logic [2:0]  idx;
    logic        hit;
    int unsigned j;
    idx = last;
    hit = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      j = (32'(last) + k) % n;
      if (k <= n && !hit && req[j[2:0]]) begin
        idx = j[2:0];
        hit = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  localparam int unsigned ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;

  modport master (output req, done, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_id, busy, timeout);

endinterface

// File: rtl/rr_pick.sv
// Combinational circular priority encoder: first set req after position last.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  logic [7:0] req_ext;
  logic [2:0] last_ext;
  logic [2:0] idx_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    last_ext             = '0;
    last_ext[ID_W-1:0]   = last;
    idx_ext              = next_rr(req_ext, last_ext, N_REQ);
  end

  assign idx   = idx_ext[ID_W-1:0];
  assign found = |req;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold-limit timeout.
// Define RR_ARBITER_ASSERT_EN to compile in the protocol assertions.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input logic        clk,
  input logic        rst_n,
  rr_arbiter_if.slave arb
);

  localparam int unsigned ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic [ID_W-1:0]  last_q;
  logic [7:0]       cnt_q;
  logic             timeout_q;

  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic [N_REQ-1:0] pick_oh;
  logic             rel_norm;
  logic             rel_force;

  // The holder is scanned last from last_q+1, so it only wins again when it is alone.
  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req   (arb.req),
    .last  (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    pick_oh   = N_REQ'(1) << pick_idx;
    rel_norm  = arb.done[gnt_id_q] | ~arb.req[gnt_id_q];
    rel_force = (cnt_q == 8'(MAX_HOLD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q    <= pick_oh;
            gnt_id_q <= pick_idx;
            last_q   <= pick_idx;
            cnt_q    <= 8'd1;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (rel_norm || rel_force) begin
            // A coincident normal release wins over the forced one.
            timeout_q <= rel_force & ~rel_norm;
            if (pick_found) begin
              gnt_q    <= pick_oh;
              gnt_id_q <= pick_idx;
              last_q   <= pick_idx;
              cnt_q    <= 8'd1;
            end else begin
              gnt_q   <= '0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.gnt_id  = gnt_id_q;
  assign arb.busy    = |gnt_q;
  assign arb.timeout = timeout_q;

`ifdef RR_ARBITER_ASSERT_EN
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q))
    else $error("%0t rr_arbiter onehot gnt=%b", $time, gnt_q);
  a_busy: assert property (@(posedge clk) disable iff (!rst_n) arb.busy == |gnt_q)
    else $error("%0t rr_arbiter busy gnt=%b", $time, gnt_q);
  a_idle_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE && |arb.req) |=> arb.busy)
    else $error("%0t rr_arbiter idle-to-busy gnt=%b", $time, gnt_q);
  a_hold: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= 8'(MAX_HOLD))
    else $error("%0t rr_arbiter hold limit gnt=%b", $time, gnt_q);
  a_timeout: assert property (@(posedge clk) disable iff (!rst_n) timeout_q |=> !timeout_q)
    else $error("%0t rr_arbiter timeout width gnt=%b", $time, gnt_q);
  a_alternate: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == GRANT && (rel_norm || rel_force) && |(arb.req & ~gnt_q))
    |=> (gnt_q != $past(gnt_q)))
    else $error("%0t rr_arbiter alternation gnt=%b", $time, gnt_q);
`endif

endmodule
